// File: rtl/seq_divider_if.sv
// -----------------------------------------------------------------------------
// seq_divider_if
// Handshake and operand/result bundle for the sequential divider.
//   start, dividend, divisor       : request side, driven by the master
//   busy, done                     : status, driven by the divider (slave)
//   quotient, remainder, div_by_zero : results, driven by the divider (slave)
// Clock and reset are not part of the bundle; they stay plain module ports.
// -----------------------------------------------------------------------------
interface seq_divider_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Unsigned sequential divider by repeated subtraction. On an accepted start
// (IDLE only) the operands are captured; each clock in SUB subtracts the
// divisor from the running remainder and bumps the quotient until the
// remainder drops below the divisor. A one-cycle done pulse marks valid
// results, which then hold until the next accepted start.
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : seq_divider_if.slave (start/dividend/divisor in,
//           busy/done/quotient/remainder/div_by_zero out)
//
// Optional feature (macro SEQ_DIV_FASTPATH_EN): at the accepting edge,
// dividend < divisor or divisor == 1 completes straight to DONE without SUB.
// Results are identical with or without the macro; only latency changes.
// -----------------------------------------------------------------------------
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_divider_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SUB  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] quot_q,  quot_d;
  logic [WIDTH-1:0] rem_q,   rem_d;
  logic [WIDTH-1:0] dvsr_q,  dvsr_d;
  logic             dbz_q,   dbz_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;

  // Next-state and datapath update for the divider FSM.
  always_comb begin
    state_d = state_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dvsr_d  = dvsr_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          dvsr_d = bus.divisor;
          rem_d  = bus.dividend;
          quot_d = {WIDTH{1'b0}};
          dbz_d  = 1'b0;
          if (bus.divisor == {WIDTH{1'b0}}) begin
            // Divide by zero: flag it, saturate quotient, pass dividend through.
            dbz_d   = 1'b1;
            quot_d  = {WIDTH{1'b1}};
            state_d = S_DONE;
          end else begin
`ifdef SEQ_DIV_FASTPATH_EN
            if (bus.dividend < bus.divisor) begin
              state_d = S_DONE;
            end else if (bus.divisor == {{(WIDTH-1){1'b0}}, 1'b1}) begin
              quot_d  = bus.dividend;
              rem_d   = {WIDTH{1'b0}};
              state_d = S_DONE;
            end else begin
              state_d = S_SUB;
            end
`else
            state_d = S_SUB;
`endif
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SUB: begin
        // Subtract only while it cannot underflow; quotient never exceeds
        // the dividend so the increment cannot overflow either.
        if (rem_q >= dvsr_q) begin
          rem_d   = rem_q - dvsr_q;
          quot_d  = quot_q + {{(WIDTH-1){1'b0}}, 1'b1};
          state_d = S_SUB;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Status flags are registered copies of the next state's decode, so they
    // always equal the Moore decode of state_q.
    busy_d = (state_d == S_SUB);
    done_d = (state_d == S_DONE);
  end

  // State and result registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      quot_q  <= {WIDTH{1'b0}};
      rem_q   <= {WIDTH{1'b0}};
      dvsr_q  <= {WIDTH{1'b0}};
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dvsr_q  <= dvsr_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
// Directed-vector bench for seq_divider (WIDTH=4). Expected quotient,
// remainder, flag and latency values are hand-computed constants; the
// latency constants switch with SEQ_DIV_FASTPATH_EN.
// -----------------------------------------------------------------------------
module tb_seq_divider;
  localparam int W = 4;
`ifdef SEQ_DIV_FASTPATH_EN
  localparam int FAST = 1;
`else
  localparam int FAST = 0;
`endif

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  seq_divider_if #(.WIDTH(W)) bus ();

  seq_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Launch one division, measure edges from the accepting edge to done,
  // count busy cycles, then check results and that done lasts one cycle.
  task automatic run_op(input string tag, input logic [W-1:0] dvd, input logic [W-1:0] dvs,
                        input int exp_lat, input logic [W-1:0] exp_q,
                        input logic [W-1:0] exp_r, input logic exp_z);
    int lat;
    int busy_cnt;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = dvd;
    bus.divisor  = dvs;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.dividend = ~dvd;
    bus.divisor  = ~dvs;
    lat      = 0;
    busy_cnt = 0;
    while (bus.done !== 1'b1 && lat < 40) begin
      if (bus.busy === 1'b1) busy_cnt++;
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_lat"},  lat, exp_lat);
    check({tag, "_busy"}, busy_cnt, exp_lat);
    check({tag, "_q"},    bus.quotient, exp_q);
    check({tag, "_r"},    bus.remainder, exp_r);
    check({tag, "_dbz"},  bus.div_by_zero, exp_z);
    @(posedge clk);
    #1;
    check({tag, "_done1"}, bus.done, 1'b0);
    check({tag, "_hold_q"}, bus.quotient, exp_q);
  endtask

  initial begin
    int lat;
    n_cmp        = 0;
    n_err        = 0;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = 4'd0;
    bus.divisor  = 4'd0;

    #12;
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_q",    bus.quotient, 4'd0);
    check("rst_r",    bus.remainder, 4'd0);
    check("rst_dbz",  bus.div_by_zero, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run_op("d7_2",  4'd7,  4'd2, 4,                    4'd3,  4'd1, 1'b0);
    run_op("d15_1", 4'd15, 4'd1, (FAST != 0) ? 0 : 16, 4'd15, 4'd0, 1'b0);
    run_op("d5_0",  4'd5,  4'd0, 0,                    4'hF,  4'd5, 1'b1);
    run_op("d3_5",  4'd3,  4'd5, (FAST != 0) ? 0 : 1,  4'd0,  4'd3, 1'b0);
    run_op("d0_5",  4'd0,  4'd5, (FAST != 0) ? 0 : 1,  4'd0,  4'd0, 1'b0);
    run_op("d6_6",  4'd6,  4'd6, 2,                    4'd1,  4'd0, 1'b0);

    // Idle hold: results stay readable with start low.
    repeat (3) @(posedge clk);
    #1;
    check("idle_q",    bus.quotient, 4'd1);
    check("idle_r",    bus.remainder, 4'd0);
    check("idle_busy", bus.busy, 1'b0);

    // 9/3 with stray starts during SUB and DONE.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 4'd9;
    bus.divisor  = 4'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat       = 0;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 4'd8;
    bus.divisor  = 4'd2;
    @(posedge clk);
    #1;
    lat++;
    bus.start = 1'b0;
    while (bus.done !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("ign_lat", lat, 4);
    check("ign_q",   bus.quotient, 4'd3);
    check("ign_r",   bus.remainder, 4'd0);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("ign_done_busy", bus.busy, 1'b0);
    check("ign_done_done", bus.done, 1'b0);
    check("ign_done_q",    bus.quotient, 4'd3);
    @(posedge clk);
    #1;
    check("ign_idle_busy", bus.busy, 1'b0);

    run_op("d8_2", 4'd8, 4'd2, 5, 4'd4, 4'd0, 1'b0);

    // Asynchronous reset in the middle of SUB.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 4'd15;
    bus.divisor  = (FAST != 0) ? 4'd2 : 4'd1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_busy", bus.busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", bus.busy, 1'b0);
    check("arst_done", bus.done, 1'b0);
    check("arst_q",    bus.quotient, 4'd0);
    check("arst_r",    bus.remainder, 4'd0);
    check("arst_dbz",  bus.div_by_zero, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("post_busy", bus.busy, 1'b0);
      check("post_done", bus.done, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
